// File: rtl/mode_controller.sv
// Mode/edit controller for a multi-channel time display: button edge detection, mode cycling,
// gated increment strobes and a registered channel-digit mux. Define MODE_CTRL_HOLD_EN to add a display-hold button.
module mode_controller #(
    parameter int         N_MODES   = 4,
    parameter int         DIGITS    = 9,
    parameter logic [7:0] EDIT_MASK = 8'b0000_0011,
    parameter logic [7:0] INC_MASK  = 8'b0000_0100,
    localparam int        MW        = ($clog2(N_MODES) > 1) ? $clog2(N_MODES) : 1,
    localparam int        DW        = DIGITS * 4
) (
    input  logic                  CLK,
    input  logic                  resetn,
    input  logic                  btn_mode,
    input  logic                  btn_edit,
    input  logic                  btn_inc_h,
    input  logic                  btn_inc_m,
`ifdef MODE_CTRL_HOLD_EN
    input  logic                  btn_hold,
`endif
    input  logic [N_MODES*DW-1:0] ch_digits,
    output logic [MW-1:0]         mode,
    output logic                  edit,
    output logic                  inc_h_pulse,
    output logic                  inc_m_pulse,
    output logic                  mode_changed,
    output logic [DW-1:0]         digits_out
);

`ifdef MODE_CTRL_HOLD_EN
    localparam int NB     = 5;
    localparam int B_HOLD = 4;
`else
    localparam int NB     = 4;
`endif
    localparam int B_MODE  = 0;
    localparam int B_EDIT  = 1;
    localparam int B_INC_H = 2;
    localparam int B_INC_M = 3;

    logic [NB-1:0] btn_lvl;
    logic [NB-1:0] btn_prev_d, btn_prev_q;
    logic [NB-1:0] btn_pulse;

    logic [MW-1:0] mode_d, mode_q;
    logic          edit_d, edit_q;
    logic          inc_h_d, inc_h_q;
    logic          inc_m_d, inc_m_q;
    logic          mode_changed_d, mode_changed_q;
    logic [DW-1:0] digits_d, digits_q;

    logic          mode_pulse;
    logic          edit_en;
    logic          inc_fwd_en;
    logic [DW-1:0] ch_sel;

`ifdef MODE_CTRL_HOLD_EN
    typedef enum logic {LIVE, HELD} hold_state_e;
    hold_state_e hold_state_d, hold_state_q;
`endif

    // Edge detect: pulses are combinational from the registered previous level.
    always_comb begin
`ifdef MODE_CTRL_HOLD_EN
        btn_lvl = {btn_hold, btn_inc_m, btn_inc_h, btn_edit, btn_mode};
`else
        btn_lvl = {btn_inc_m, btn_inc_h, btn_edit, btn_mode};
`endif
        btn_prev_d = btn_lvl;
        btn_pulse  = btn_lvl & ~btn_prev_q;
        mode_pulse = btn_pulse[B_MODE];
    end

    // Per-mode capability bits and channel slice, decoded from the current mode.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        edit_en    = 1'b0;
        inc_fwd_en = 1'b0;
        ch_sel     = ch_digits[DW-1:0];
        for (int i = 0; i < N_MODES; i++) begin
            if (mode_q == MW'(i)) begin
                edit_en    = EDIT_MASK[i];
                inc_fwd_en = INC_MASK[i];
                ch_sel     = ch_digits[i*DW +: DW];
            end
        end
    end

    always_comb begin
        mode_d         = mode_q;
        edit_d         = edit_q;
        inc_h_d        = 1'b0;
        inc_m_d        = 1'b0;
        mode_changed_d = 1'b0;

        if (mode_pulse) begin
            // A mode change wins over edit and increment requests in the same cycle.
            mode_d         = (mode_q == MW'(N_MODES - 1)) ? '0 : MW'(mode_q + 1'b1);
            mode_changed_d = 1'b1;
            edit_d         = 1'b0;
        end else begin
            if (btn_pulse[B_EDIT] && edit_en) begin
                edit_d = ~edit_q;
            end
            inc_h_d = btn_pulse[B_INC_H] & (edit_q | inc_fwd_en);
            inc_m_d = btn_pulse[B_INC_M] & (edit_q | inc_fwd_en);
        end
    end

`ifdef MODE_CTRL_HOLD_EN
    always_comb begin
        hold_state_d = hold_state_q;
        if (mode_pulse) begin
            hold_state_d = LIVE;
        end else if (btn_pulse[B_HOLD]) begin
            hold_state_d = (hold_state_q == LIVE) ? HELD : LIVE;
        end
        digits_d = (hold_state_q == LIVE) ? ch_sel : digits_q;
    end
`else
    always_comb begin
        digits_d = ch_sel;
    end
`endif

    // Previous levels reset high so a button held through reset release stays silent.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            btn_prev_q     <= '1;
            mode_q         <= '0;
            edit_q         <= 1'b0;
            inc_h_q        <= 1'b0;
            inc_m_q        <= 1'b0;
            mode_changed_q <= 1'b0;
            digits_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            btn_prev_q     <= btn_prev_d;
            mode_q         <= mode_d;
            edit_q         <= edit_d;
            inc_h_q        <= inc_h_d;
            inc_m_q        <= inc_m_d;
            mode_changed_q <= mode_changed_d;
            digits_q       <= digits_d;
        end
    end

`ifdef MODE_CTRL_HOLD_EN
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            hold_state_q <= LIVE;
        end else begin
            hold_state_q <= hold_state_d;
        end
    end
`endif

    assign mode         = mode_q;
    assign edit         = edit_q;
    assign inc_h_pulse  = inc_h_q;
    assign inc_m_pulse  = inc_m_q;
    assign mode_changed = mode_changed_q;
    assign digits_out   = digits_q;

endmodule

// File: tb/tb_mode_controller.sv
// Self-checking bench for mode_controller: reset behaviour, a per-cycle vector table checked through
// a scoreboard queue, and hand sequences for digit latency and (with MODE_CTRL_HOLD_EN) display hold.
module tb_mode_controller;

    localparam int N_MODES = 4;
    localparam int DIGITS  = 9;
    localparam int DW      = DIGITS * 4;

    logic                  CLK;
    logic                  resetn;
    logic                  btn_mode, btn_edit, btn_inc_h, btn_inc_m;
`ifdef MODE_CTRL_HOLD_EN
    logic                  btn_hold;
`endif
    logic [N_MODES*DW-1:0] ch_digits;
    logic [1:0]            mode;
    logic                  edit, inc_h_pulse, inc_m_pulse, mode_changed;
    logic [DW-1:0]         digits_out;

    mode_controller dut (
        .CLK          (CLK),
        .resetn       (resetn),
        .btn_mode     (btn_mode),
        .btn_edit     (btn_edit),
        .btn_inc_h    (btn_inc_h),
        .btn_inc_m    (btn_inc_m),
`ifdef MODE_CTRL_HOLD_EN
        .btn_hold     (btn_hold),
`endif
        .ch_digits    (ch_digits),
        .mode         (mode),
        .edit         (edit),
        .inc_h_pulse  (inc_h_pulse),
        .inc_m_pulse  (inc_m_pulse),
        .mode_changed (mode_changed),
        .digits_out   (digits_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] btn;   // {mode, edit, inc_h, inc_m}
        logic [1:0] mode;
        logic       edit, ih, im, mc;
    } vec_t;

    typedef struct {
        int         idx;
        logic [1:0] mode;
        logic       edit, ih, im, mc;
        logic [DW-1:0] digits;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t v(input logic [3:0] b, input int md, input int ed,
                               input int ih, input int im, input int mc);
        vec_t r;
        r.btn  = b;
        r.mode = 2'(md);
        r.edit = (ed != 0);
        r.ih   = (ih != 0);
        r.im   = (im != 0);
        r.mc   = (mc != 0);
        return r;
    endfunction

    task automatic set_chan(input int c, input logic [DW-1:0] val);
        ch_digits[c*DW +: DW] = val;
    endtask

    function automatic logic [DW-1:0] chan(input int c);
        return ch_digits[c*DW +: DW];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int            prev_mode;
        logic          saw_change;
        logic [DW-1:0] frozen;

        resetn    = 1'b0;
        btn_mode  = 1'b0;
        btn_edit  = 1'b0;
        btn_inc_h = 1'b0;
        btn_inc_m = 1'b0;
`ifdef MODE_CTRL_HOLD_EN
        btn_hold  = 1'b0;
`endif
        ch_digits = '0;
        set_chan(0, 36'h987654321);
        set_chan(1, 36'h123456789);
        set_chan(2, 36'h555000555);
        set_chan(3, 36'h246802468);

        repeat (2) tick();
        check("reset mode", 64'(mode), 64'd0);
        check("reset edit", 64'(edit), 64'd0);
        check("reset inc_h", 64'(inc_h_pulse), 64'd0);
        check("reset inc_m", 64'(inc_m_pulse), 64'd0);
        check("reset mode_changed", 64'(mode_changed), 64'd0);
        check("reset digits", 64'(digits_out), 64'd0);

        // Button held through reset release must not count as a press.
        btn_mode = 1'b1;
        tick();
        resetn = 1'b1;
        saw_change = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (mode !== 2'd0 || mode_changed !== 1'b0) saw_change = 1'b1;
        end
        check("held-through-reset no change", 64'(saw_change), 64'd0);
        btn_mode = 1'b0;
        tick();
        btn_mode = 1'b1;
        tick();
        check("re-press mode", 64'(mode), 64'd1);
        check("re-press mode_changed", 64'(mode_changed), 64'd1);
        btn_mode = 1'b0;
        tick();
        check("mode_changed one cycle", 64'(mode_changed), 64'd0);
        check("mode stays 1", 64'(mode), 64'd1);

        // Asynchronous reset in the middle of an active strobe.
        btn_mode = 1'b1;
        tick();
        check("pre-reset mode", 64'(mode), 64'd2);
        check("pre-reset mode_changed", 64'(mode_changed), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("async reset mode", 64'(mode), 64'd0);
        check("async reset mode_changed", 64'(mode_changed), 64'd0);
        check("async reset digits", 64'(digits_out), 64'd0);
        btn_mode = 1'b0;
        tick();
        resetn = 1'b1;

        vecs.push_back(v(4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(v(4'b1000, 1, 0, 0, 0, 1));
        vecs.push_back(v(4'b0000, 1, 0, 0, 0, 0));
        vecs.push_back(v(4'b1000, 2, 0, 0, 0, 1));
        vecs.push_back(v(4'b0000, 2, 0, 0, 0, 0));
        vecs.push_back(v(4'b0100, 2, 0, 0, 0, 0));
        vecs.push_back(v(4'b0000, 2, 0, 0, 0, 0));
        vecs.push_back(v(4'b0001, 2, 0, 0, 1, 0));
        vecs.push_back(v(4'b0000, 2, 0, 0, 0, 0));
        vecs.push_back(v(4'b0010, 2, 0, 1, 0, 0));
        vecs.push_back(v(4'b0000, 2, 0, 0, 0, 0));
        vecs.push_back(v(4'b0001, 2, 0, 0, 1, 0));
        vecs.push_back(v(4'b0001, 2, 0, 0, 0, 0));
        vecs.push_back(v(4'b0001, 2, 0, 0, 0, 0));
        vecs.push_back(v(4'b0000, 2, 0, 0, 0, 0));
        vecs.push_back(v(4'b1001, 3, 0, 0, 0, 1));
        vecs.push_back(v(4'b0000, 3, 0, 0, 0, 0));
        vecs.push_back(v(4'b0001, 3, 0, 0, 0, 0));
        vecs.push_back(v(4'b0000, 3, 0, 0, 0, 0));
        vecs.push_back(v(4'b0100, 3, 0, 0, 0, 0));
        vecs.push_back(v(4'b0000, 3, 0, 0, 0, 0));
        vecs.push_back(v(4'b1000, 0, 0, 0, 0, 1));
        vecs.push_back(v(4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(v(4'b0001, 0, 0, 0, 0, 0));
        vecs.push_back(v(4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(v(4'b0100, 0, 1, 0, 0, 0));
        vecs.push_back(v(4'b0000, 0, 1, 0, 0, 0));
        vecs.push_back(v(4'b0010, 0, 1, 1, 0, 0));
        vecs.push_back(v(4'b0000, 0, 1, 0, 0, 0));
        vecs.push_back(v(4'b0001, 0, 1, 0, 1, 0));
        vecs.push_back(v(4'b0000, 0, 1, 0, 0, 0));
        vecs.push_back(v(4'b1100, 1, 0, 0, 0, 1));
        vecs.push_back(v(4'b0000, 1, 0, 0, 0, 0));
        vecs.push_back(v(4'b0100, 1, 1, 0, 0, 0));
        vecs.push_back(v(4'b0100, 1, 1, 0, 0, 0));
        vecs.push_back(v(4'b0000, 1, 1, 0, 0, 0));
        vecs.push_back(v(4'b0100, 1, 0, 0, 0, 0));
        vecs.push_back(v(4'b0000, 1, 0, 0, 0, 0));
        vecs.push_back(v(4'b0100, 1, 1, 0, 0, 0));
        vecs.push_back(v(4'b0000, 1, 1, 0, 0, 0));
        vecs.push_back(v(4'b1010, 2, 0, 0, 0, 1));
        vecs.push_back(v(4'b0000, 2, 0, 0, 0, 0));

        prev_mode = 0;
        for (int r = 0; r < vecs.size(); r++) begin
            exp_t e;
            {btn_mode, btn_edit, btn_inc_h, btn_inc_m} = vecs[r].btn;
            e.idx    = r;
            e.mode   = vecs[r].mode;
            e.edit   = vecs[r].edit;
            e.ih     = vecs[r].ih;
            e.im     = vecs[r].im;
            e.mc     = vecs[r].mc;
            e.digits = chan(prev_mode);
            sb.push_back(e);
            prev_mode = int'(vecs[r].mode);
            tick();
            e = sb.pop_front();
            check($sformatf("row%0d mode", e.idx), 64'(mode), 64'(e.mode));
            check($sformatf("row%0d edit", e.idx), 64'(edit), 64'(e.edit));
            check($sformatf("row%0d inc_h", e.idx), 64'(inc_h_pulse), 64'(e.ih));
            check($sformatf("row%0d inc_m", e.idx), 64'(inc_m_pulse), 64'(e.im));
            check($sformatf("row%0d mode_changed", e.idx), 64'(mode_changed), 64'(e.mc));
            check($sformatf("row%0d digits", e.idx), 64'(digits_out), 64'(e.digits));
        end
        btn_mode  = 1'b0;
        btn_edit  = 1'b0;
        btn_inc_h = 1'b0;
        btn_inc_m = 1'b0;

        // Mode 2 -> 3 -> 0, then into mode 1 and watch the digit mux lag by one cycle.
        for (int p = 0; p < 2; p++) begin
            btn_mode = 1'b1;
            tick();
            btn_mode = 1'b0;
            tick();
        end
        btn_mode = 1'b1;
        tick();
        check("ch1 select mode", 64'(mode), 64'd1);
        check("ch1 select old digits", 64'(digits_out), 64'h987654321);
        btn_mode = 1'b0;
        tick();
        check("ch1 select new digits", 64'(digits_out), 64'h123456789);
        set_chan(1, 36'h000000042);
        tick();
        check("ch1 live update", 64'(digits_out), 64'h000000042);

`ifdef MODE_CTRL_HOLD_EN
        btn_hold = 1'b1;
        tick();
        btn_hold = 1'b0;
        frozen = 36'h000000042;
        for (int k = 1; k <= 10; k++) begin
            set_chan(1, 36'(k * 36'h111111111));
            tick();
            check($sformatf("held digits %0d", k), 64'(digits_out), 64'(frozen));
        end
        set_chan(2, 36'h777888999);
        btn_mode = 1'b1;
        tick();
        check("held mode press mode", 64'(mode), 64'd2);
        check("held mode press digits", 64'(digits_out), 64'(frozen));
        btn_mode = 1'b0;
        tick();
        check("live after mode press", 64'(digits_out), 64'h777888999);
        btn_hold = 1'b1;
        btn_mode = 1'b1;
        tick();
        btn_hold = 1'b0;
        btn_mode = 1'b0;
        tick();
        set_chan(3, 36'h135792468);
        tick();
        check("hold+mode stays live", 64'(digits_out), 64'h135792468);
`else
        frozen = chan(1);
        tick();
        check("no hold digits live", 64'(digits_out), 64'(frozen));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mode_controller.md
MODE_CONTROLLER -- requirements
Module: mode_controller

Interface
REQ-001 Parameter N_MODES, default 4: number of time-source channels; legal range 2..8.
REQ-002 Parameter DIGITS, default 9: BCD digits per channel, 4 bits each, ordered k0,k1,k2,s0,s1,m0,m1,h0,h1 from LSB.
REQ-003 Parameter EDIT_MASK, default 8'b0000_0011: bit i set means mode i accepts edit toggling.
REQ-004 Parameter INC_MASK, default 8'b0000_0100: bit i set means mode i forwards increment pulses without edit.
REQ-005 Localparam MW = max(1, clog2(N_MODES)).
REQ-006 CLK  in  1  system clock; all state changes on its rising edge.
REQ-007 resetn  in  1  asynchronous, active-low reset.
REQ-008 btn_mode, btn_edit, btn_inc_h, btn_inc_m  in  1 each  debounced, CLK-synchronous levels.
REQ-009 ch_digits  in  N_MODES*DIGITS*4  concatenated channel digits; channel i at [i*DIGITS*4 +: DIGITS*4].
REQ-010 mode  out  MW  current mode index.
REQ-011 edit  out  1  edit-active flag.
REQ-012 inc_h_pulse, inc_m_pulse  out  1 each  one-cycle gated increment strobes.
REQ-013 mode_changed  out  1  one-cycle strobe in the cycle mode takes its new value.
REQ-014 digits_out  out  DIGITS*4  registered selected digits.

Function
REQ-015 Each button SHALL have a previous-level register; pulse = level & ~prev, combinational from registered prev, consumed at the same edge.
REQ-016 Mode pulse SHALL advance mode by 1 and wrap from N_MODES-1 to 0.
REQ-017 mode_changed SHALL be 1 exactly in the cycle following a mode pulse edge and 0 otherwise.
REQ-018 Edit pulse SHALL toggle edit only when EDIT_MASK[mode]=1; otherwise ignored.
REQ-019 Mode change SHALL clear edit in the same edge; simultaneous mode+edit pulses: mode advances, edit=0.
REQ-020 inc_h_pulse/inc_m_pulse SHALL be registered: 1 for one cycle after a button pulse when (edit=1 or INC_MASK[mode]=1), evaluated with the pre-edge mode; suppressed on a cycle with a simultaneous mode pulse.
REQ-021 digits_out SHALL register channel[mode] every cycle: one-cycle latency from ch_digits and from a mode update.
REQ-022 A held button SHALL generate exactly one pulse per rising level, regardless of hold duration.

Reset
REQ-023 While resetn=0: mode=0, edit=0, inc pulses=0, mode_changed=0, digits_out=0, hold state LIVE.
REQ-024 prev registers SHALL reset to 1 so a button held through reset release yields no pulse until released and re-pressed.
REQ-025 Reset asserted mid-operation SHALL override all pending pulses in the same instant.

Configuration
REQ-026 Macro MODE_CTRL_HOLD_EN defined: add input btn_hold (1 bit) with edge detect, and a two-state FSM LIVE/HELD.
REQ-027 With MODE_CTRL_HOLD_EN: hold pulse toggles LIVE<->HELD; in HELD digits_out SHALL keep its last value while ch_digits changes; a mode pulse SHALL force LIVE and load the new channel as REQ-021; simultaneous hold+mode pulses: mode wins, LIVE.
REQ-028 Without MODE_CTRL_HOLD_EN: no btn_hold port, no FSM, digits_out always live.

Verification
REQ-029 Reset release with btn_mode held high, then 100 cycles -> mode stays 0; release and press -> mode=1, mode_changed high one cycle.
REQ-030 Defaults, four mode presses -> mode 1,2,3,0; edit press in mode 2 -> edit stays 0.
REQ-031 Mode 0, press edit -> edit=1; press inc_h -> inc_h_pulse one cycle; press mode and edit same cycle -> mode=1, edit=0, no inc pulse.
REQ-032 Mode 2, edit=0, press inc_m -> inc_m_pulse one cycle; mode 3 same press -> none.
REQ-033 Drive channel 1 = 9'h… digits 0x12_34_56_789 pattern, select mode 1 -> digits_out equals channel 1 slice one cycle after mode update.
REQ-034 With MODE_CTRL_HOLD_EN: press hold, change ch_digits 10 times -> digits_out frozen; press mode -> LIVE, new channel shown next cycle.
